// File: rtl/mips_next_address_logic.sv
// Program counter and next-address unit for a single-cycle MIPS datapath.
//
// Holds the 32-bit PC and updates it on every rising clock edge. The next PC
// is PC+4, a taken conditional branch target, or a pseudo-direct jump target.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   rst          in   1   synchronous active-high reset, PC <- 0x00000000
//   instruction  in  32   fetched word; [15:0] branch imm, [25:0] jump index
//   branch       in   1   current instruction is a conditional branch
//   zero         in   1   ALU zero flag; branch taken only with branch = 1
//   jump         in   1   current instruction is a jump; overrides branch
//   addr         out 32   current PC, straight from the PC register
module mips_next_address_logic (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] addr
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] br_mux;
   logic        br_taken;

   // Opcode bits are decoded elsewhere; they do not affect the next address.
   logic        unused_opcode;
   assign unused_opcode = ^instruction[31:26];

   always_comb begin
      pc_plus4 = pc_q + 32'd4;

      // Sign-extend the 16-bit immediate and scale words to bytes.
      br_off   = {{14{instruction[15]}}, instruction[15:0], 2'b00};
      br_tgt   = pc_plus4 + br_off;

      // Pseudo-direct: keep the 256 MB region of the following instruction.
      j_tgt    = {pc_plus4[31:28], instruction[25:0], 2'b00};

      br_taken = branch & zero;
      br_mux   = br_taken ? br_tgt : pc_plus4;

      // Jump mux sits after the branch mux so branch/zero are don't-care
      // whenever jump is asserted.
      pc_d     = jump ? j_tgt : br_mux;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= 32'h0000_0000;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign addr = pc_q;

endmodule

// File: tb/tb_mips_next_address_logic.sv
module tb_mips_next_address_logic;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] addr;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   logic [31:0] exp_pc;
   logic        exp_valid = 1'b0;

   mips_next_address_logic dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .addr        (addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: next PC from the architectural rules, plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic br, input logic z, input logic j,
                                            input logic r);
      longint unsigned seq;
      longint          off;
      longint unsigned region;
      if (r) return 32'h0;
      seq = (longint'(pc) + 4) % 64'h1_0000_0000;
      if (j) begin
         region = seq - (seq % 64'h1000_0000);
         return 32'(region + longint'(ins[25:0]) * 4);
      end
      if (br === 1'b1 && z === 1'b1) begin
         off = longint'($signed(ins[15:0])) * 4;
         return 32'((longint'(seq) + off + 64'h1_0000_0000) % 64'h1_0000_0000);
      end
      return 32'(seq);
   endfunction

   always @(posedge clk) begin
      exp_pc <= ref_next(exp_pc, instruction, branch, zero, jump, rst);
      if (rst) exp_valid <= 1'b1;
   end

   // Single compare process, sampled on the falling edge.
   always @(negedge clk) begin
      if (exp_valid) begin
         n_checks++;
         if (addr !== exp_pc) begin
            n_fails++;
            $display("FAIL model_cmp t=%0t addr=%h expected=%h", $time, addr, exp_pc);
         end
         n_checks++;
         if (addr[1:0] !== 2'b00) begin
            n_fails++;
            $display("FAIL align t=%0t addr=%h low bits must be 00", $time, addr);
         end
      end
   end

   // Drive one cycle of inputs, then pin the result to a hand-computed value.
   task automatic step(input string name, input logic r, input logic [31:0] ins,
                       input logic br, input logic z, input logic j,
                       input logic [31:0] want);
      rst         = r;
      instruction = ins;
      branch      = br;
      zero        = z;
      jump        = j;
      @(posedge clk);
      #2;
      n_checks++;
      if (addr !== want) begin
         n_fails++;
         $display("FAIL %s addr=%h expected=%h", name, addr, want);
      end
   endtask

   initial begin
      rst         = 1'b1;
      instruction = 32'h0;
      branch      = 1'b0;
      zero        = 1'b0;
      jump        = 1'b0;

      step("reset1",      1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("reset2",      1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("seq4",        0, 32'h0000_0000, 0, 0, 0, 32'h0000_0004);
      step("seq8",        0, 32'h0000_0000, 0, 0, 0, 32'h0000_0008);
      step("br_not_take", 0, 32'h0000_1000, 1, 0, 0, 32'h0000_000C);
      step("reset3",      1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("seq4b",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_0004);
      step("seq8b",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_0008);
      step("br_taken",    0, 32'h0000_1000, 1, 1, 0, 32'h0000_400C);
      step("jump_x",      0, 32'h0008_0000, 1'bx, 1'bx, 1, 32'h0020_0000);
      step("reset4",      1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("seq_a",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_0004);
      step("seq_b",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_0008);
      step("seq_c",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_000C);
      step("seq_d",       0, 32'h0000_0000, 0, 0, 0, 32'h0000_0010);
      step("br_back",     0, 32'h0000_FFFE, 1, 1, 0, 32'h0000_000C);
      step("reset5",      1, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("br_wrap_neg", 0, 32'h0000_FFFD, 1, 1, 0, 32'hFFFF_FFF8);
      step("jump_region", 0, 32'h0000_0000, 0, 0, 1, 32'hF000_0000);
      step("jump_nibble", 0, 32'h03FF_FFFF, 0, 0, 1, 32'hFFFF_FFFC);
      step("seq_wrap",    0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000);
      step("seq_post",    0, 32'h0000_0000, 0, 0, 0, 32'h0000_0004);
      step("rst_on_jump", 1, 32'h03FF_FFFF, 1, 1, 1, 32'h0000_0000);
      step("rst_release", 0, 32'h03FF_FFFF, 0, 0, 0, 32'h0000_0004);

      // Randomised phase; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 63) == 0);
         instruction = $urandom;
         branch      = $urandom_range(0, 1);
         zero        = $urandom_range(0, 1);
         jump        = ($urandom_range(0, 3) == 0);
         @(posedge clk);
         #2;
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
